// File: rtl/nn_multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the NN simulator core.
// Fetches 16-bit instructions, steps them through ALU1/ALU2/dmem/regfile, and tracks faults and retirements.
module nn_multicycle_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    output logic                imem_req_o,
    input  logic                imem_ack_i,
    input  logic [15:0]         imem_rdata_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    input  logic                dmem_ack_i,
    output logic [2:0]          alu_ctrl1_o,
    output logic [2:0]          alu_ctrl2_o,
    output logic                alu_src_o,
    output logic                reg_write_o,
    output logic                mem_to_reg_o,
    output logic                busy_o,
    output logic                halted_o,
    output logic [1:0]          fault_o,
    output logic [15:0]         retired_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_MAC  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hE;
    localparam logic [3:0] OP_ST   = 4'hF;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_IMEM    = 2'b10;
    localparam logic [1:0] FAULT_DMEM    = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_MUL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_IDLE = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC1,
        S_EXEC2,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [15:0]         retired_q, retired_d;
    logic [1:0]          fault_q, fault_d;
    logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                retireNow;
    logic                advancePc;
    logic [3:0]          opcode;
    logic                unused_irBits;

    assign opcode        = ir_q[15:12];
    assign unused_irBits = ^ir_q[11:0];

    function automatic logic isExecOp(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_MUL, OP_SLT, OP_MAC, OP_LD, OP_ST: isExecOp = 1'b1;
            default:                                               isExecOp = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            fault_q   <= FAULT_NONE;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        waitCnt_d = waitCnt_q;
        retireNow = 1'b0;
        advancePc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_FETCH;
                    waitCnt_d = '0;
                end
            end
            // An ack in the final allowed wait cycle still completes the fetch.
            S_FETCH: begin
                if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = S_DECODE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    fault_d = FAULT_IMEM;
                    state_d = S_ERROR;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    retireNow = 1'b1;
                    advancePc = 1'b1;
                    state_d   = S_FETCH;
                    waitCnt_d = '0;
                end else if (opcode == OP_HALT) begin
                    retireNow = 1'b1;
                    state_d   = S_HALT;
                end else if (isExecOp(opcode)) begin
                    state_d = S_EXEC1;
                end else begin
                    fault_d = FAULT_ILLEGAL;
                    state_d = S_ERROR;
                end
            end
            S_EXEC1: begin
                if (opcode == OP_MAC) begin
                    state_d = S_EXEC2;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    state_d   = S_MEM;
                    waitCnt_d = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_EXEC2: state_d = S_WB;
            S_MEM: begin
                if (dmem_ack_i) begin
                    if (opcode == OP_ST) begin
                        retireNow = 1'b1;
                        advancePc = 1'b1;
                        state_d   = S_FETCH;
                        waitCnt_d = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (waitCnt_q == WAIT_LAST) begin
                    fault_d = FAULT_DMEM;
                    state_d = S_ERROR;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                retireNow = 1'b1;
                advancePc = 1'b1;
                state_d   = S_FETCH;
                waitCnt_d = '0;
            end
            S_HALT, S_ERROR: state_d = state_q;
            default:         state_d = S_IDLE;
        endcase

        if (retireNow && retired_q != 16'hFFFF) begin
            retired_d = retired_q + 16'd1;
        end
        if (advancePc) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    // Strobes depend only on state and the latched opcode, never on live inputs.
    always_comb begin
        imem_req_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        alu_ctrl1_o  = ALU_IDLE;
        alu_ctrl2_o  = ALU_IDLE;
        alu_src_o    = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;

        case (state_q)
            S_FETCH: imem_req_o = 1'b1;
            S_EXEC1: begin
                case (opcode)
                    OP_MUL, OP_MAC: alu_ctrl1_o = ALU_MUL;
                    OP_SLT:         alu_ctrl1_o = ALU_SLT;
                    default:        alu_ctrl1_o = ALU_ADD;
                endcase
                alu_src_o = (opcode == OP_ADDI);
            end
            S_EXEC2: begin
                alu_ctrl1_o = ALU_MUL;
                alu_ctrl2_o = ALU_ADD;
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (opcode == OP_ST);
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (opcode == OP_LD);
            end
            default: ;
        endcase
    end

    assign pc_o      = pc_q;
    assign retired_o = retired_q;
    assign fault_o   = fault_q;
    assign busy_o    = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERROR);
    assign halted_o  = (state_q == S_HALT || state_q == S_ERROR);

endmodule

// File: tb/tb_nn_multicycle_sequencer.sv
// Self-checking bench for nn_multicycle_sequencer: directed scenarios plus random programs
// checked against a per-instruction latency/strobe model.
module tb_nn_multicycle_sequencer;

    localparam int PCW = 2;
    localparam int TMO = 15;
    localparam logic [3:0] LEGAL_OPS [8] = '{4'h0, 4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF};

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           imemReq;
    logic           imemAck;
    logic [15:0]    imemRdata;
    logic [PCW-1:0] pc;
    logic           dmemReq;
    logic           dmemWe;
    logic           dmemAck;
    logic [2:0]     aluCtrl1;
    logic [2:0]     aluCtrl2;
    logic           aluSrc;
    logic           regWrite;
    logic           memToReg;
    logic           busy;
    logic           halted;
    logic [1:0]     fault;
    logic [15:0]    retired;

    nn_multicycle_sequencer #(.PC_WIDTH(PCW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .imem_req_o(imemReq), .imem_ack_i(imemAck), .imem_rdata_i(imemRdata),
        .pc_o(pc), .dmem_req_o(dmemReq), .dmem_we_o(dmemWe), .dmem_ack_i(dmemAck),
        .alu_ctrl1_o(aluCtrl1), .alu_ctrl2_o(aluCtrl2), .alu_src_o(aluSrc),
        .reg_write_o(regWrite), .mem_to_reg_o(memToReg), .busy_o(busy),
        .halted_o(halted), .fault_o(fault), .retired_o(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         lat;
        int         regW;
        int         m2r;
        int         dreq;
        int         dwe;
        int         alu2;
        int         alu1Cyc;
        int         src;
        logic [2:0] alu1;
        logic [1:0] fault;
        logic       halt;
        logic       retire;
        logic       advance;
    } expect_t;

    int errors = 0;
    int checks = 0;
    int mPc;
    int mRet;
    int mFault;
    int sBusy, sRegW, sM2r, sDreq, sDwe, sAlu2, sAlu1, sSrc, sFetchReq;
    logic [2:0] lastAlu1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Expected per-instruction behaviour from the opcode table and memory wait count.
    function automatic expect_t predict(input logic [3:0] op, input int dDelay);
        expect_t e;
        int      memCycles;
        bit      timedOut;
        e         = '0;
        e.alu1    = 3'b111;
        timedOut  = (dDelay >= TMO);
        memCycles = timedOut ? TMO : dDelay + 1;
        case (op)
            4'h0: begin e.lat = 2; e.retire = 1'b1; e.advance = 1'b1; end
            4'h1, 4'h9, 4'h2, 4'h3: begin
                e.lat = 4; e.regW = 1; e.alu1Cyc = 1;
                e.alu1 = (op == 4'h2) ? 3'b001 : (op == 4'h3) ? 3'b010 : 3'b000;
                e.src = (op == 4'h9) ? 1 : 0;
                e.retire = 1'b1; e.advance = 1'b1;
            end
            4'h4: begin
                e.lat = 5; e.regW = 1; e.alu1Cyc = 2; e.alu1 = 3'b001; e.alu2 = 1;
                e.retire = 1'b1; e.advance = 1'b1;
            end
            4'hE, 4'hF: begin
                e.alu1Cyc = 1; e.alu1 = 3'b000; e.dreq = memCycles;
                e.dwe = (op == 4'hF) ? memCycles : 0;
                if (timedOut) begin
                    e.lat = 3 + memCycles; e.fault = 2'b11; e.halt = 1'b1;
                end else begin
                    e.lat  = 3 + memCycles + ((op == 4'hE) ? 1 : 0);
                    e.regW = (op == 4'hE) ? 1 : 0;
                    e.m2r  = e.regW;
                    e.retire = 1'b1; e.advance = 1'b1;
                end
            end
            4'hB:    begin e.lat = 2; e.retire = 1'b1; e.halt = 1'b1; end
            default: begin e.lat = 2; e.fault = 2'b01; e.halt = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic sampleCycle();
        if (busy === 1'b1)                     sBusy++;
        if (regWrite === 1'b1)                 sRegW++;
        if (memToReg === 1'b1)                 sM2r++;
        if (dmemReq === 1'b1)                  sDreq++;
        if (dmemReq === 1'b1 && dmemWe === 1'b1) sDwe++;
        if (aluCtrl2 === 3'b000)               sAlu2++;
        if (aluSrc === 1'b1)                   sSrc++;
        if (aluCtrl1 !== 3'b111) begin
            sAlu1++;
            lastAlu1 = aluCtrl1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1; start = 1'b0; imemAck = 1'b0; dmemAck = 1'b0; imemRdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mPc = 0; mRet = 0; mFault = 0;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset pc", pc, 0);
        checkOutput("reset retired", retired, 0);
        checkOutput("reset fault", fault, 0);
        checkOutput("reset imemReq", imemReq, 0);
        checkOutput("reset dmemReq", dmemReq, 0);
        checkOutput("reset regWrite", regWrite, 0);
        checkOutput("reset aluCtrl1", aluCtrl1, 3'b111);
        checkOutput("reset aluCtrl2", aluCtrl2, 3'b111);
    endtask

    task automatic doStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from its first fetch cycle until the next fetch or a halted state.
    task automatic applyStimulus(input logic [15:0] instr, input int iDelay, input int dDelay, input string name);
        expect_t e;
        int      cyc;
        int      dCnt;
        e = predict(instr[15:12], dDelay);
        sBusy = 0; sRegW = 0; sM2r = 0; sDreq = 0; sDwe = 0; sAlu2 = 0; sAlu1 = 0; sSrc = 0; sFetchReq = 0;
        lastAlu1 = 3'b111;
        checkOutput({name, " fetch pc"}, pc, mPc);
        for (int i = 0; i <= iDelay; i++) begin
            sampleCycle();
            if (imemReq === 1'b1) sFetchReq++;
            imemAck   = (i == iDelay);
            imemRdata = (i == iDelay) ? instr : 16'($urandom);
            dmemAck   = 1'($urandom);
            @(negedge clk);
        end
        imemAck = 1'b0;
        cyc  = iDelay + 1;
        dCnt = 0;
        while (imemReq !== 1'b1 && halted !== 1'b1 && cyc < 80) begin
            sampleCycle();
            if (dmemReq === 1'b1) begin
                dCnt++;
                dmemAck = (dCnt == dDelay + 1);
            end else begin
                dmemAck = 1'($urandom);
            end
            imemAck   = 1'($urandom);
            imemRdata = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        imemAck = 1'b0;
        dmemAck = 1'b0;

        if (e.retire && mRet < 16'hFFFF) mRet++;
        if (e.advance) mPc = (mPc + 1) % (1 << PCW);
        if (e.fault != 2'b00) mFault = e.fault;

        checkOutput({name, " fetchReq"}, sFetchReq, iDelay + 1);
        checkOutput({name, " latency"}, cyc, e.lat + iDelay);
        checkOutput({name, " busyCycles"}, sBusy, e.lat + iDelay);
        checkOutput({name, " regWrite"}, sRegW, e.regW);
        checkOutput({name, " memToReg"}, sM2r, e.m2r);
        checkOutput({name, " dmemReq"}, sDreq, e.dreq);
        checkOutput({name, " dmemWe"}, sDwe, e.dwe);
        checkOutput({name, " alu2Add"}, sAlu2, e.alu2);
        checkOutput({name, " alu1Cycles"}, sAlu1, e.alu1Cyc);
        checkOutput({name, " alu1Op"}, lastAlu1, e.alu1);
        checkOutput({name, " aluSrc"}, sSrc, e.src);
        checkOutput({name, " halted"}, halted, e.halt);
        checkOutput({name, " fault"}, fault, mFault);
        checkOutput({name, " pc"}, pc, mPc);
        checkOutput({name, " retired"}, retired, mRet);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [3:0] op;

        // Basic program: ADD, MAC, HALT with zero-wait acks.
        doReset();
        doStart();
        applyStimulus(16'h1000, 0, 0, "add");
        applyStimulus(16'h4000, 0, 0, "mac");
        applyStimulus(16'hB000, 0, 0, "halt");
        checkOutput("program halted pc", pc, 2);
        checkOutput("program retired", retired, 3);

        // Memory operations with wait states and the timeout boundary.
        doReset();
        doStart();
        applyStimulus(16'hE000, 0, 3, "ld-wait3");
        applyStimulus(16'hF000, 0, 0, "st");
        applyStimulus(16'hF123, 1, 14, "st-ackAtLimit");
        applyStimulus(16'hE456, 0, 15, "ld-timeout");

        // Illegal opcode, then start toggling must be ignored.
        doReset();
        doStart();
        applyStimulus(16'h5000, 0, 0, "illegal");
        for (int i = 0; i < 6; i++) begin
            start = 1'(i);
            @(negedge clk);
            checkOutput("illegal hold halted", halted, 1);
            checkOutput("illegal hold imemReq", imemReq, 0);
            checkOutput("illegal hold fault", fault, 2'b01);
            checkOutput("illegal hold busy", busy, 0);
        end
        start = 1'b0;

        // Fetch timeout: no ack for the whole window.
        doReset();
        doStart();
        n = 0;
        while (imemReq === 1'b1 && n < 40) begin
            imemAck = 1'b0;
            @(negedge clk);
            n++;
        end
        checkOutput("imemTimeout reqCycles", n, TMO);
        checkOutput("imemTimeout halted", halted, 1);
        checkOutput("imemTimeout fault", fault, 2'b10);

        // Fetch ack arriving in the last allowed cycle completes normally.
        doReset();
        doStart();
        applyStimulus(16'h1234, TMO - 1, 0, "imem-ackAtLimit");

        // PC wrap with four NOPs.
        doReset();
        doStart();
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, 0, 0, "nop-wrap");
        checkOutput("wrap pc", pc, 0);
        checkOutput("wrap retired", retired, 4);

        // Randomised programs terminated by HALT or an illegal opcode.
        for (int r = 0; r < 3; r++) begin
            doReset();
            doStart();
            for (int k = 0; k < 30; k++) begin
                op = LEGAL_OPS[$urandom_range(0, 7)];
                applyStimulus({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 4), "random");
            end
            if (r == 1) applyStimulus(16'hA5A5, $urandom_range(0, 2), 0, "random-illegal");
            else        applyStimulus(16'hB000, $urandom_range(0, 2), 0, "random-halt");
        end

        // Reset in the middle of a data-memory access.
        doReset();
        doStart();
        applyStimulus(16'h1000, 0, 0, "pre-reset add");
        imemAck   = 1'b1;
        imemRdata = 16'hE000;
        @(negedge clk);
        imemAck = 1'b0;
        n = 0;
        while (dmemReq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midMem reached", dmemReq, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midMem busy", busy, 0);
        checkOutput("midMem dmemReq", dmemReq, 0);
        checkOutput("midMem pc", pc, 0);
        checkOutput("midMem retired", retired, 0);
        @(negedge clk);
        checkOutput("midMem idle holds", busy, 0);
        checkOutput("midMem no fetch", imemReq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nn_multicycle_sequencer.md
Name: nn_multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the NN simulator core.
- Fetches 16-bit instructions over an imem handshake and decodes opcode = ir[15:12].
- Steps each instruction through the ALU1/ALU2/data-memory/register-file datapath, driving per-state control strobes.
- Sits between instruction memory and the datapath. Handles MAC's two ALU passes, memory wait states, HALT, illegal opcodes and memory timeouts.

Parameters:
- PC_WIDTH, 8, program counter width; wraps modulo 2^PC_WIDTH.
- TIMEOUT, 15, maximum cycles to wait for imem_ack/dmem_ack before faulting; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leaves IDLE when high.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch done; imem_rdata valid this cycle.
- imem_rdata  in  16  instruction word.
- pc  out  PC_WIDTH  current instruction address.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  write enable, qualified by dmem_req.
- dmem_ack  in  1  data access done.
- alu_ctrl1  out  3  ALU1 op: 000 ADD, 001 MUL, 010 SLT, 111 idle.
- alu_ctrl2  out  3  ALU2 op: 000 ADD, 111 idle.
- alu_src  out  1  immediate operand select (ADDI).
- reg_write  out  1  register file write strobe.
- mem_to_reg  out  1  writeback source select: memory.
- busy  out  1  high in any state other than IDLE, HALT or ERROR.
- halted  out  1  high in HALT or ERROR.
- fault  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- retired  out  16  count of retired instructions; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, takes priority over everything including mid-transaction):
  - state IDLE, pc 0, ir 0, retired 0, fault 00, wait counter 0.
  - All strobes 0; alu_ctrl1/alu_ctrl2 = 111.
  - Any outstanding request is dropped.
- Opcode map:
  - 0 NOP, 1 ADD, 9 ADDI, 2 MUL, 3 SLT, 4 MAC, E LD, F ST, B HALT.
  - All other opcodes are illegal.
- Output timing: all outputs are registered or decoded from state plus ir. No combinational path from an input to any output.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1 until ack.
  - ack is allowed in the first cycle of the request.
  - On imem_ack: ir<=imem_rdata -> DECODE.
- DECODE (1 cycle):
  - NOP: pc+1, retired+1 -> FETCH.
  - HALT: retired+1 -> HALT; pc unchanged.
  - Illegal opcode: fault=01 -> ERROR.
  - Otherwise -> EXEC1.
- EXEC1 (1 cycle):
  - alu_ctrl1 per opcode: ADD/ADDI/LD/ST=000, MUL/MAC=001, SLT=010.
  - alu_src=1 only for ADDI.
  - Next: MAC -> EXEC2; LD/ST -> MEM; else -> WB.
- EXEC2 (MAC only, 1 cycle): alu_ctrl1=001, alu_ctrl2=000 -> WB.
- MEM:
  - dmem_req=1 until dmem_ack.
  - dmem_we=1 for ST, 0 for LD.
  - On ack: LD -> WB; ST does pc+1, retired+1 -> FETCH.
- WB (1 cycle):
  - reg_write=1; mem_to_reg=1 only for LD.
  - pc+1, retired+1 -> FETCH.
- alu_ctrl1/alu_ctrl2 are 111 in all states other than EXEC1 and EXEC2.
- HALT and ERROR: absorbing until reset; start ignored; halted=1; no requests issued.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - If the counter reaches TIMEOUT with no ack: fault=10 (FETCH) or 11 (MEM) -> ERROR.
  - An ack in the same cycle the counter reaches TIMEOUT wins; no fault.
- pc wraps from 2^PC_WIDTH-1 to 0 with no flag.
- retired holds at FFFF.
- Latency with zero-wait acks: NOP 2, ADD/ADDI/MUL/SLT 4, ST 4, MAC 5, LD 5 cycles.
- Each memory wait cycle adds 1.
- Spurious acks (ack asserted outside FETCH/MEM) are ignored.

Test Plan:
- Reset, then start=1 and program {1000, 4000, B000} with zero-wait acks.
  - -> ADD retires at cycle 4, MAC at cycle 9.
  - -> halted=1 with pc=2 and retired=3.
  - -> alu_ctrl2=000 for exactly one cycle.
- LD (E000) with dmem_ack delayed 3 cycles.
  - -> dmem_req high 4 cycles with dmem_we=0.
  - -> then reg_write=1 and mem_to_reg=1 for one cycle; total latency 8.
- ST (F000).
  - -> dmem_we=1 during MEM, reg_write never asserted, pc increments by 1.
- Illegal opcode 5000.
  - -> fault=01, halted=1, no reg_write.
  - -> start toggling ignored until reset.
- imem_ack withheld with TIMEOUT=15.
  - -> fault=10 after 15 request cycles.
  - -> ack arriving exactly on cycle 15 fetches normally instead.
- PC_WIDTH=2 with four NOPs.
  - -> pc sequence 0,1,2,3,0.
- Reset asserted mid-MEM.
  - -> next cycle IDLE, dmem_req=0, pc=0, retired=0.
